// File: rtl/axi_rd_ram_slave_pkg.sv
// Shared types and constants for the AXI read-only RAM slave.
// Holds the response/burst codes, the FSM state enum and the beat address stepping.
package axi_rd_ram_slave_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_READ = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // WRAP is stepped linearly like INCR; only FIXED holds the address.
    function automatic logic [31:0] next_beat_addr(input logic [31:0] addr,
                                                   input logic [2:0]  size,
                                                   input logic [1:0]  burst);
        if (burst == BURST_FIXED) begin
            return addr;
        end
        return addr + (32'd1 << size);
    endfunction

endpackage

// File: rtl/axi_rd_ram_slave_ram.sv
// 32-bit wide RAM with one registered read port and one byte-strobed write port.
// Each byte lane is its own array so the write strobes map onto independent memories.
module sync_ram_1r1w #(
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [31:0]       rdata,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [31:0]       wdata,
    input  logic [3:0]        wstrb
);

    localparam int DEPTH = 1 << ADDR_W;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] mem [DEPTH];
            logic [7:0] rd_byte_reg;

            // Non-blocking read and write give read-before-write on a same-word collision.
            always_ff @(posedge clk) begin
                if (we && wstrb[gi]) begin
                    mem[waddr] <= wdata[gi*8 +: 8];
                end
                if (re) begin
                    rd_byte_reg <= mem[raddr];
                end
            end

            assign rdata[gi*8 +: 8] = rd_byte_reg;
        end
    endgenerate

endmodule

// File: rtl/axi_rd_ram_slave.sv
// AXI4 read-only slave in front of a backdoor-writable RAM.
// One transaction at a time: IDLE accepts AR, READ fetches a word, RESP presents the beat.
module axi_rd_ram_slave
    import axi_rd_ram_slave_pkg::*;
#(
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic [3:0]        arid,
    input  logic [31:0]       araddr,
    input  logic [7:0]        arlen,
    input  logic [2:0]        arsize,
    input  logic [1:0]        arburst,
    input  logic [1:0]        arlock,
    input  logic [3:0]        arcache,
    input  logic [2:0]        arprot,
    input  logic              arvalid,
    output logic              arready,
    output logic [3:0]        rid,
    output logic [31:0]       rdata,
    output logic [1:0]        rresp,
    output logic              rlast,
    output logic              rvalid,
    input  logic              rready,
    input  logic              ram_we,
    input  logic [ADDR_W-1:0] ram_waddr,
    input  logic [31:0]       ram_wdata,
    input  logic [3:0]        ram_wstrb
);

    state_t      state_reg, state_next;
    logic [3:0]  id_reg;
    logic [31:0] addr_reg;
    logic [7:0]  len_reg;
    logic [2:0]  size_reg;
    logic [1:0]  burst_reg;
    logic [7:0]  beat_reg;
    logic [31:0] ram_rdata;
    logic        beat_err;
    logic        last_beat;
    logic        unused_inputs;

    assign unused_inputs = ^{arlock, arcache, arprot, addr_reg[1:0]};

    sync_ram_1r1w #(.ADDR_W(ADDR_W)) u_ram (
        .clk   (clk),
        .re    (state_reg == ST_READ),
        .raddr (addr_reg[ADDR_W+1:2]),
        .rdata (ram_rdata),
        .we    (ram_we),
        .waddr (ram_waddr),
        .wdata (ram_wdata),
        .wstrb (ram_wstrb)
    );

    // Evaluated on the current beat address, so a burst can run off the top of RAM mid-way.
    assign beat_err  = (addr_reg[31:ADDR_W+2] != '0) || (size_reg > 3'd2) || (burst_reg == 2'b11);
    assign last_beat = (beat_reg == len_reg);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: if (arvalid) state_next = ST_READ;
            ST_READ: state_next = ST_RESP;
            ST_RESP: if (rready) state_next = last_beat ? ST_IDLE : ST_READ;
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            id_reg    <= '0;
            addr_reg  <= '0;
            len_reg   <= '0;
            size_reg  <= '0;
            burst_reg <= '0;
            beat_reg  <= '0;
        end else if (state_reg == ST_IDLE && arvalid) begin
            id_reg    <= arid;
            addr_reg  <= araddr;
            len_reg   <= arlen;
            size_reg  <= arsize;
            burst_reg <= arburst;
            beat_reg  <= '0;
        end else if (state_reg == ST_RESP && rready && !last_beat) begin
            beat_reg  <= beat_reg + 8'd1;
            addr_reg  <= next_beat_addr(addr_reg, size_reg, burst_reg);
        end
    end

    // RAM read register only loads in READ, so rdata holds through any R backpressure.
    always_comb begin
        arready = 1'b0;
        rvalid  = 1'b0;
        rlast   = 1'b0;
        rresp   = RESP_OKAY;
        rdata   = '0;
        case (state_reg)
            ST_IDLE: arready = 1'b1;
            ST_RESP: begin
                rvalid = 1'b1;
                rlast  = last_beat;
                rresp  = beat_err ? RESP_SLVERR : RESP_OKAY;
                rdata  = beat_err ? 32'd0 : ram_rdata;
            end
            default: ;
        endcase
    end

    assign rid = id_reg;

endmodule

// File: tb/tb_axi_rd_ram_slave.sv
// Directed bench for axi_rd_ram_slave: single beats, bursts, backpressure, errors,
// reset mid-burst and backdoor collisions, each checked against hand-computed values.
module tb_axi_rd_ram_slave;

    localparam int AW = 12;

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic [3:0]    arid = '0;
    logic [31:0]   araddr = '0;
    logic [7:0]    arlen = '0;
    logic [2:0]    arsize = '0;
    logic [1:0]    arburst = '0;
    logic [1:0]    arlock = '0;
    logic [3:0]    arcache = '0;
    logic [2:0]    arprot = '0;
    logic          arvalid = 1'b0;
    logic          arready;
    logic [3:0]    rid;
    logic [31:0]   rdata;
    logic [1:0]    rresp;
    logic          rlast;
    logic          rvalid;
    logic          rready = 1'b0;
    logic          ram_we = 1'b0;
    logic [AW-1:0] ram_waddr = '0;
    logic [31:0]   ram_wdata = '0;
    logic [3:0]    ram_wstrb = '0;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    axi_rd_ram_slave #(.ADDR_W(AW)) dut (
        .clk(clk), .resetn(resetn),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arlock(arlock), .arcache(arcache), .arprot(arprot),
        .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
        .ram_we(ram_we), .ram_waddr(ram_waddr), .ram_wdata(ram_wdata), .ram_wstrb(ram_wstrb)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bd_write(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] s);
        ram_we = 1'b1; ram_waddr = a; ram_wdata = d; ram_wstrb = s;
        tick();
        ram_we = 1'b0;
        $display("txn W: word=%0d data=%08h strb=%04b", a, d, s);
    endtask

    // Presents AR for one cycle; returns in the cycle after the handshake edge.
    task automatic do_ar(input logic [3:0] id, input logic [31:0] a, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst, output bit tmo);
        int n = 0;
        while (arready !== 1'b1 && n < 20) begin tick(); n++; end
        tmo = (arready !== 1'b1);
        arid = id; araddr = a; arlen = len; arsize = size; arburst = burst; arvalid = 1'b1;
        tick();
        arvalid = 1'b0;
        $display("txn AR: id=%0d addr=%08h len=%0d size=%0d burst=%0d", id, a, len, size, burst);
    endtask

    // Waits for rvalid, holds rready low for 'hold' cycles watching stability, then accepts.
    task automatic get_beat(input int hold, output logic [31:0] d, output logic [1:0] resp,
                            output logic last, output logic [3:0] id, output int lat,
                            output bit stable, output bit tmo);
        lat = 0; tmo = 1'b0; stable = 1'b1;
        d = '0; resp = '0; last = 1'b0; id = '0;
        while (rvalid !== 1'b1 && lat < 20) begin tick(); lat++; end
        if (rvalid !== 1'b1) begin
            tmo = 1'b1;
            return;
        end
        d = rdata; resp = rresp; last = rlast; id = rid;
        for (int i = 0; i < hold; i++) begin
            tick();
            if (rvalid !== 1'b1 || rdata !== d || rresp !== resp || rlast !== last || rid !== id)
                stable = 1'b0;
        end
        rready = 1'b1;
        tick();
        rready = 1'b0;
        $display("txn R: id=%0d data=%08h resp=%0d last=%0b lat=%0d", id, d, resp, last, lat);
    endtask

    task automatic test_reset();
        tick(); tick();
        checks++; if (arready !== 1'b1) begin errors++; $display("FAIL reset_arready got=%0b want=1", arready); end
        checks++; if (rvalid !== 1'b0) begin errors++; $display("FAIL reset_rvalid got=%0b want=0", rvalid); end
        checks++;
        if ({rid, rdata, rresp, rlast} !== 39'd0) begin
            errors++; $display("FAIL reset_outputs rid=%0d rdata=%08h rresp=%0d rlast=%0b want all 0", rid, rdata, rresp, rlast);
        end
        resetn = 1'b1;
    endtask

    task automatic test_single_beat();
        logic [31:0] d; logic [1:0] resp; logic last; logic [3:0] id; int lat; bit st, tmo;
        bd_write(12'd5, 32'hDEADBEEF, 4'hF);
        do_ar(4'd3, 32'h14, 8'd0, 3'd2, 2'b01, tmo);
        checks++; if (rvalid !== 1'b0) begin errors++; $display("FAIL single_read_cycle rvalid=%0b want=0", rvalid); end
        get_beat(0, d, resp, last, id, lat, st, tmo);
        checks++; if (tmo) begin errors++; $display("FAIL single_timeout rvalid never rose want=1"); end
        checks++; if (lat != 1) begin errors++; $display("FAIL single_latency got=%0d want=1", lat); end
        checks++; if (d !== 32'hDEADBEEF) begin errors++; $display("FAIL single_data got=%08h want=deadbeef", d); end
        checks++; if (id !== 4'd3 || resp !== 2'b00 || last !== 1'b1) begin
            errors++; $display("FAIL single_ctrl id=%0d resp=%0d last=%0b want 3/0/1", id, resp, last);
        end
        checks++; if (arready !== 1'b1 || rvalid !== 1'b0) begin
            errors++; $display("FAIL single_return_idle arready=%0b rvalid=%0b want 1/0", arready, rvalid);
        end
    endtask

    task automatic test_incr_burst();
        logic [31:0] d; logic [1:0] resp; logic last; logic [3:0] id; int lat; bit st, tmo;
        for (int i = 0; i < 4; i++) bd_write(AW'(i), 32'h10 + i, 4'hF);
        do_ar(4'd1, 32'h0, 8'd3, 3'd2, 2'b01, tmo);
        for (int i = 0; i < 4; i++) begin
            get_beat(0, d, resp, last, id, lat, st, tmo);
            checks++;
            if (tmo || d !== 32'h10 + i || lat != 1 || last !== (i == 3) || resp !== 2'b00) begin
                errors++;
                $display("FAIL incr_beat%0d data=%08h lat=%0d last=%0b resp=%0d want %08h/1/%0b/0",
                         i, d, lat, last, resp, 32'h10 + i, (i == 3));
            end
        end
        checks++; if (arready !== 1'b1) begin errors++; $display("FAIL incr_end_arready got=%0b want=1", arready); end
    endtask

    task automatic test_backpressure_fixed();
        logic [31:0] d; logic [1:0] resp; logic last; logic [3:0] id; int lat; bit st, tmo;
        do_ar(4'd7, 32'h8, 8'd2, 3'd2, 2'b00, tmo);
        for (int i = 0; i < 3; i++) begin
            get_beat(3, d, resp, last, id, lat, st, tmo);
            checks++;
            if (tmo || !st || d !== 32'h12 || last !== (i == 2) || id !== 4'd7) begin
                errors++;
                $display("FAIL fixed_beat%0d data=%08h stable=%0b last=%0b id=%0d want 00000012/1/%0b/7",
                         i, d, st, last, id, (i == 2));
            end
        end
        tick();
        checks++; if (rvalid !== 1'b0) begin errors++; $display("FAIL fixed_extra_beat rvalid=%0b want=0", rvalid); end
    endtask

    task automatic test_strobe();
        logic [31:0] d; logic [1:0] resp; logic last; logic [3:0] id; int lat; bit st, tmo;
        bd_write(12'd9, 32'hFFFFFFFF, 4'hF);
        bd_write(12'd9, 32'h00000000, 4'b0101);
        do_ar(4'd2, 32'h24, 8'd0, 3'd2, 2'b01, tmo);
        get_beat(0, d, resp, last, id, lat, st, tmo);
        checks++; if (tmo || d !== 32'hFF00FF00) begin errors++; $display("FAIL strobe_data got=%08h want=ff00ff00", d); end
    endtask

    task automatic test_errors();
        logic [31:0] d; logic [1:0] resp; logic last; logic [3:0] id; int lat; bit st, tmo;
        do_ar(4'd4, 32'h0001_0000, 8'd0, 3'd2, 2'b01, tmo);
        get_beat(0, d, resp, last, id, lat, st, tmo);
        checks++; if (tmo || resp !== 2'b10 || d !== 32'd0 || last !== 1'b1) begin
            errors++; $display("FAIL err_range resp=%0d data=%08h last=%0b want 2/00000000/1", resp, d, last);
        end
        bd_write(12'd4095, 32'hCAFEF00D, 4'hF);
        do_ar(4'd5, 32'h3FFC, 8'd1, 3'd2, 2'b01, tmo);
        get_beat(0, d, resp, last, id, lat, st, tmo);
        checks++; if (tmo || resp !== 2'b00 || d !== 32'hCAFEF00D || last !== 1'b0) begin
            errors++; $display("FAIL err_cross_beat1 resp=%0d data=%08h last=%0b want 0/cafef00d/0", resp, d, last);
        end
        get_beat(0, d, resp, last, id, lat, st, tmo);
        checks++; if (tmo || resp !== 2'b10 || d !== 32'd0 || last !== 1'b1) begin
            errors++; $display("FAIL err_cross_beat2 resp=%0d data=%08h last=%0b want 2/00000000/1", resp, d, last);
        end
        do_ar(4'd6, 32'h0, 8'd0, 3'd3, 2'b01, tmo);
        get_beat(0, d, resp, last, id, lat, st, tmo);
        checks++; if (tmo || resp !== 2'b10 || d !== 32'd0) begin
            errors++; $display("FAIL err_size resp=%0d data=%08h want 2/00000000", resp, d);
        end
        do_ar(4'd6, 32'h4, 8'd0, 3'd2, 2'b11, tmo);
        get_beat(0, d, resp, last, id, lat, st, tmo);
        checks++; if (tmo || resp !== 2'b10 || d !== 32'd0) begin
            errors++; $display("FAIL err_burst resp=%0d data=%08h want 2/00000000", resp, d);
        end
    endtask

    task automatic test_ignore_busy();
        logic [31:0] d; logic [1:0] resp; logic last; logic [3:0] id; int lat; bit st, tmo;
        do_ar(4'd1, 32'h14, 8'd0, 3'd2, 2'b01, tmo);
        tick();
        arid = 4'd9; araddr = 32'h0; arvalid = 1'b1;
        tick(); tick();
        checks++; if (arready !== 1'b0) begin errors++; $display("FAIL busy_arready got=%0b want=0", arready); end
        arvalid = 1'b0;
        get_beat(0, d, resp, last, id, lat, st, tmo);
        checks++; if (tmo || d !== 32'hDEADBEEF || id !== 4'd1) begin
            errors++; $display("FAIL busy_beat data=%08h id=%0d want deadbeef/1", d, id);
        end
        tick(); tick(); tick();
        checks++; if (rvalid !== 1'b0 || rid !== 4'd1) begin
            errors++; $display("FAIL busy_not_latched rvalid=%0b rid=%0d want 0/1", rvalid, rid);
        end
    endtask

    task automatic test_reset_mid_burst();
        logic [31:0] d; logic [1:0] resp; logic last; logic [3:0] id; int lat; bit st, tmo;
        do_ar(4'd2, 32'h0, 8'd7, 3'd2, 2'b01, tmo);
        get_beat(0, d, resp, last, id, lat, st, tmo);
        tick();
        checks++; if (rvalid !== 1'b1) begin errors++; $display("FAIL rst_beat2_present rvalid=%0b want=1", rvalid); end
        resetn = 1'b0;
        #1;
        checks++; if (rvalid !== 1'b0 || rlast !== 1'b0 || arready !== 1'b1 || rid !== 4'd0 || rdata !== 32'd0) begin
            errors++; $display("FAIL rst_immediate rvalid=%0b rlast=%0b arready=%0b rid=%0d rdata=%08h want 0/0/1/0/0",
                               rvalid, rlast, arready, rid, rdata);
        end
        tick(); tick(); tick();
        checks++; if (rvalid !== 1'b0) begin errors++; $display("FAIL rst_held rvalid=%0b want=0", rvalid); end
        resetn = 1'b1;
        do_ar(4'd4, 32'h0, 8'd0, 3'd2, 2'b01, tmo);
        get_beat(0, d, resp, last, id, lat, st, tmo);
        checks++; if (tmo || lat != 1 || d !== 32'h10 || last !== 1'b1 || id !== 4'd4) begin
            errors++; $display("FAIL rst_after data=%08h lat=%0d last=%0b id=%0d want 00000010/1/1/4", d, lat, last, id);
        end
    endtask

    task automatic test_collision();
        logic [31:0] d; logic [1:0] resp; logic last; logic [3:0] id; int lat; bit st, tmo;
        bd_write(12'd7, 32'h77777777, 4'hF);
        do_ar(4'd8, 32'h1C, 8'd0, 3'd2, 2'b01, tmo);
        ram_we = 1'b1; ram_waddr = 12'd7; ram_wdata = 32'hAAAA5555; ram_wstrb = 4'hF;
        tick();
        ram_we = 1'b0;
        get_beat(0, d, resp, last, id, lat, st, tmo);
        checks++; if (tmo || d !== 32'h77777777) begin errors++; $display("FAIL collide_old got=%08h want=77777777", d); end
        do_ar(4'd8, 32'h1C, 8'd0, 3'd2, 2'b01, tmo);
        get_beat(0, d, resp, last, id, lat, st, tmo);
        checks++; if (tmo || d !== 32'hAAAA5555) begin errors++; $display("FAIL collide_new got=%08h want=aaaa5555", d); end
    endtask

    initial begin
        test_reset();
        test_single_beat();
        test_incr_burst();
        test_backpressure_fixed();
        test_strobe();
        test_errors();
        test_ignore_busy();
        test_reset_mid_burst();
        test_collision();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
